// File: rtl/gnn_counter_pkg.sv
// Shared types and limits for the GNN loop index generator.
package gnn_counter_pkg;

    localparam int MAX_DIMS = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/loop_dim_stage.sv
// One dimension of the nested loop: index register with wrap at the latched
// inclusive bound, advanced by the carry from the inner dimensions.
module loop_dim_stage #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             at_last
);

    // Equality compare keeps an all-ones bound usable without overflow.
    assign at_last = (idx == last);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx <= '0;
        end else if (advance) begin
            idx <= at_last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/nested_loop_counter.sv
// Runtime-bounded multi-dimensional index generator over a valid/ready stream,
// dimension 0 innermost, with abort and a registered done pulse.
module nested_loop_counter
    import gnn_counter_pkg::*;
#(
    parameter int NUM_DIMS = 3,
    parameter int IDX_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [NUM_DIMS*IDX_W-1:0] cfg_last,
    input  logic                      abort,
    output logic                      idx_valid,
    input  logic                      idx_ready,
    output logic [NUM_DIMS*IDX_W-1:0] idx,
    output logic [NUM_DIMS-1:0]       idx_last,
    output logic                      busy,
    output logic                      done
);

    state_t                    state;
    state_t                    state_nxt;
    logic [NUM_DIMS*IDX_W-1:0] last_q;
    logic [NUM_DIMS-1:0]       at_last;
    logic [NUM_DIMS-1:0]       carry;
    logic                      run;
    logic                      accept;
    logic                      beat;
    logic                      final_beat;
    logic                      clear;

    assign run        = (state == RUN);
    assign accept     = cfg_valid && !run;
    assign beat       = run && idx_ready;
    assign final_beat = beat && (&at_last);
    assign clear      = accept || (run && abort);

    // Dimension d advances on a beat only when every inner dimension is at its bound.
    for (genvar d = 0; d < NUM_DIMS; d++) begin : g_dim
        if (d == 0) begin : g_first
            assign carry[d] = beat;
        end else begin : g_chain
            assign carry[d] = carry[d-1] && at_last[d-1];
        end

        loop_dim_stage #(
            .IDX_W (IDX_W)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear),
            .advance (carry[d]),
            .last    (last_q[d*IDX_W +: IDX_W]),
            .idx     (idx[d*IDX_W +: IDX_W]),
            .at_last (at_last[d])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            last_q <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= final_beat && !abort;
            if (accept) begin
                last_q <= cfg_last;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        idx_valid = 1'b0;
        busy      = 1'b0;
        idx_last  = '0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                idx_valid = 1'b1;
                busy      = 1'b1;
                idx_last  = at_last;
                if (abort || final_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nested_loop_counter.sv
// Self-checking bench for nested_loop_counter: scoreboard of expected tuples,
// table-driven jobs, and hand-written abort/reset/narrow-width sequences.
module tb_nested_loop_counter;

    localparam int ND = 3;
    localparam int W  = 8;

    typedef struct {
        logic [ND*W-1:0] idx;
        logic [ND-1:0]   lst;
    } exp_t;

    typedef struct {
        logic [ND*W-1:0] cfg;
        bit              stall;
        int              beats;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [ND*W-1:0] cfg_last;
    logic            abort;
    logic            idx_valid;
    logic            idx_ready;
    logic [ND*W-1:0] idx;
    logic [ND-1:0]   idx_last;
    logic            busy;
    logic            done;

    logic            cfg_valid4;
    logic            cfg_ready4;
    logic [7:0]      cfg_last4;
    logic            idx_valid4;
    logic            ready4;
    logic [7:0]      idx4;
    logic [1:0]      idx_last4;
    logic            busy4;
    logic            done4;

    always #5 clk = ~clk;

    nested_loop_counter #(.NUM_DIMS(ND), .IDX_W(W)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_last(cfg_last), .abort(abort), .idx_valid(idx_valid), .idx_ready(idx_ready),
        .idx(idx), .idx_last(idx_last), .busy(busy), .done(done)
    );

    nested_loop_counter #(.NUM_DIMS(2), .IDX_W(4)) dut4 (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid4), .cfg_ready(cfg_ready4),
        .cfg_last(cfg_last4), .abort(abort), .idx_valid(idx_valid4), .idx_ready(ready4),
        .idx(idx4), .idx_last(idx_last4), .busy(busy4), .done(done4)
    );

    int              checks = 0;
    int              errors = 0;
    int              job_beats = 0;
    exp_t            sb[$];
    exp_t            mon_e;
    bit              done_exp = 1'b0;
    bit              prev_hold = 1'b0;
    bit              stall_en = 1'b0;
    logic [ND*W-1:0] prev_idx;
    vec_t            vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every beat.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            done_exp  = 1'b0;
            prev_hold = 1'b0;
        end else begin
            chk("done", done, done_exp);
            if (done_exp) chk("ready_at_done", cfg_ready, 1);
            done_exp = 1'b0;
            chk("valid_tracks_busy", idx_valid, busy);
            if (prev_hold) chk("stall_hold", idx, prev_idx);
            if (busy && abort) begin
                sb.delete();
            end else if (idx_valid && idx_ready) begin
                chk("beat_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("idx", idx, mon_e.idx);
                    chk("idx_last", idx_last, mon_e.lst);
                    job_beats++;
                    if (mon_e.lst == '1) done_exp = 1'b1;
                end
            end
            prev_hold = busy && idx_valid && !idx_ready && !abort;
            prev_idx  = idx;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        idx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic push_job(input logic [ND*W-1:0] c);
        exp_t e;
        int   l0, l1, l2;
        l0 = int'(c[7:0]);
        l1 = int'(c[15:8]);
        l2 = int'(c[23:16]);
        for (int i2 = 0; i2 <= l2; i2++)
            for (int i1 = 0; i1 <= l1; i1++)
                for (int i0 = 0; i0 <= l0; i0++) begin
                    e.idx = {W'(i2), W'(i1), W'(i0)};
                    e.lst = {i2 == l2, i1 == l1, i0 == l0};
                    sb.push_back(e);
                end
    endtask

    task automatic start_job(input logic [ND*W-1:0] c, output int base);
        int n = 0;
        while (!cfg_ready && n < 2000) begin
            step();
            n++;
        end
        chk("ready_before_start", cfg_ready, 1);
        base      = job_beats;
        cfg_valid = 1'b1;
        cfg_last  = c;
        push_job(c);
        step();
        cfg_valid = 1'b0;
        cfg_last  = ~c;
        chk("first_valid", idx_valid, 1);
        chk("first_idx", idx, 0);
        chk("busy_in_run", busy, 1);
        chk("cfg_ready_in_run", cfg_ready, 0);
    endtask

    task automatic finish_job(input int base, input int exp_beats);
        int n = 0;
        while (busy && n < 5000) begin
            step();
            n++;
        end
        chk("job_ended", busy, 0);
        chk("done_pulse", done, 1);
        chk("beat_count", job_beats - base, exp_beats);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic wait_beats(input int base, input int target);
        int n = 0;
        while ((job_beats - base) < target && n < 500) begin
            step();
            n++;
        end
        chk("reached_beat", job_beats - base, target);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
        chk({tag, "_valid"}, idx_valid, 0);
        chk({tag, "_idx"}, idx, 0);
        chk({tag, "_idx_last"}, idx_last, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int base;

        vecs[0] = '{cfg: {8'd1, 8'd2, 8'd3},   stall: 1'b0, beats: 24};
        vecs[1] = '{cfg: {8'd0, 8'd0, 8'd0},   stall: 1'b0, beats: 1};
        vecs[2] = '{cfg: {8'd2, 8'd2, 8'd2},   stall: 1'b1, beats: 27};
        vecs[3] = '{cfg: {8'd0, 8'd3, 8'd0},   stall: 1'b1, beats: 4};
        vecs[4] = '{cfg: {8'd0, 8'd1, 8'd255}, stall: 1'b0, beats: 512};

        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_last   = '0;
        abort      = 1'b0;
        idx_ready  = 1'b1;
        cfg_valid4 = 1'b0;
        cfg_last4  = '0;
        ready4     = 1'b1;
        step();
        step();
        check_idle("reset");
        reset = 1'b0;

        // Back-to-back jobs: each starts in the done cycle of the previous one.
        for (int v = 0; v < 5; v++) begin
            stall_en = vecs[v].stall;
            start_job(vecs[v].cfg, base);
            finish_job(base, vecs[v].beats);
        end
        stall_en = 1'b0;
        step();

        // Abort on the fifth beat.
        start_job({8'd2, 8'd2, 8'd2}, base);
        wait_beats(base, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort5");
        step();
        chk("abort5_no_done", done, 0);

        // Abort coincident with the final beat.
        start_job({8'd0, 8'd1, 8'd1}, base);
        wait_beats(base, 3);
        chk("final_last_bits", idx_last, 3'b111);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort_final");
        step();
        chk("abort_final_no_done", done, 0);

        // Abort while idle leaves the block idle.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort_idle");

        // One-cycle reset mid-run, then a fresh job from zero.
        start_job({8'd2, 8'd2, 8'd2}, base);
        wait_beats(base, 6);
        reset = 1'b1;
        step();
        check_idle("reset_mid");
        reset = 1'b0;
        step();
        start_job(vecs[0].cfg, base);
        finish_job(base, vecs[0].beats);
        step();

        // Narrow 4-bit instance: inner dimension runs its full 0..15 range.
        chk("w4_ready", cfg_ready4, 1);
        cfg_last4  = {4'd1, 4'd15};
        cfg_valid4 = 1'b1;
        step();
        cfg_valid4 = 1'b0;
        cfg_last4  = '0;
        for (int b = 0; b < 32; b++) begin
            chk("w4_valid", idx_valid4, 1);
            chk("w4_idx", idx4, {4'(b / 16), 4'(b % 16)});
            chk("w4_last", idx_last4, {b / 16 == 1, b % 16 == 15});
            step();
        end
        chk("w4_done", done4, 1);
        chk("w4_idle", busy4, 0);
        chk("w4_idx_zero", idx4, 0);
        step();
        chk("w4_done_pulse", done4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
